// File: rtl/matrix_output_drain_pkg.sv
// Shared definitions for the matrix result drain: state encoding, default
// geometry (common with matrixMult and its bench) and an element slice helper.
package matrix_output_drain_pkg;

  localparam int unsigned DEF_BATCH_SIZE          = 8;
  localparam int unsigned DEF_LOG_BATCH_SIZE      = 3;
  localparam int unsigned DEF_OUTPUT_FEATURES     = 8;
  localparam int unsigned DEF_LOG_OUTPUT_FEATURES = 3;
  localparam int unsigned DEF_OUTPUT_WIDTH        = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } drain_state_t;

  function automatic logic [DEF_OUTPUT_WIDTH-1:0] elem_slice(
    input logic [DEF_OUTPUT_FEATURES*DEF_OUTPUT_WIDTH-1:0] row,
    input logic [DEF_LOG_OUTPUT_FEATURES-1:0]              col
  );
    return row[col*DEF_OUTPUT_WIDTH +: DEF_OUTPUT_WIDTH];
  endfunction

endpackage

// File: rtl/matrix_row_buffer.sv
// Row storage for the drain: one synchronous write port, one combinational
// read port. Contents are never reset.
module matrix_row_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned ROW_W  = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ROW_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ROW_W-1:0]  rdata
);

  logic [ROW_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/matrix_output_drain.sv
// Captures a full result matrix row by row from the multiply engine, then
// streams it element by element (row-major) over a valid/ready interface.
module matrix_output_drain
  import matrix_output_drain_pkg::*;
#(
  parameter int unsigned BATCH_SIZE          = DEF_BATCH_SIZE,
  parameter int unsigned LOG_BATCH_SIZE      = DEF_LOG_BATCH_SIZE,
  parameter int unsigned OUTPUT_FEATURES     = DEF_OUTPUT_FEATURES,
  parameter int unsigned LOG_OUTPUT_FEATURES = DEF_LOG_OUTPUT_FEATURES,
  parameter int unsigned OUTPUT_WIDTH        = DEF_OUTPUT_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData,
  input  logic [LOG_BATCH_SIZE-1:0]               outputAddr,
  input  logic                                    outputWrEn,
  output logic                                    outValid,
  input  logic                                    outReady,
  output logic [OUTPUT_WIDTH-1:0]                 outData,
  output logic [LOG_BATCH_SIZE-1:0]               outRow,
  output logic [LOG_OUTPUT_FEATURES-1:0]          outCol,
  output logic                                    outLast,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    overrun
);

  localparam int unsigned ROW_W = OUTPUT_FEATURES * OUTPUT_WIDTH;
  localparam logic [LOG_BATCH_SIZE-1:0]      LAST_ROW = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
  localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

  drain_state_t                   state_q, state_d;
  logic [BATCH_SIZE-1:0]          row_valid_q, row_valid_d;
  logic [LOG_BATCH_SIZE-1:0]      row_idx_q, row_idx_d;
  logic [LOG_OUTPUT_FEATURES-1:0] col_idx_q, col_idx_d;
  logic                           done_q, done_d;
  logic                           overrun_q, overrun_d;
  logic                           buf_we;
  logic                           at_last;
  logic [ROW_W-1:0]               rd_row;

  matrix_row_buffer #(
    .DEPTH  (BATCH_SIZE),
    .ADDR_W (LOG_BATCH_SIZE),
    .ROW_W  (ROW_W)
  ) u_row_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (outputAddr),
    .wdata (outputData),
    .raddr (row_idx_q),
    .rdata (rd_row)
  );

  assign at_last = (row_idx_q == LAST_ROW) && (col_idx_q == LAST_COL);

  always_comb begin
    state_d     = state_q;
    row_valid_d = row_valid_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    buf_we      = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (outputWrEn) begin
          buf_we                  = 1'b1;
          row_valid_d[outputAddr] = 1'b1;
          // Completion is judged on the updated bitmap so DRAIN starts at the capturing edge.
          state_d = (&row_valid_d) ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (outputWrEn) begin
          overrun_d = 1'b1;
        end
        if (outReady) begin
          if (at_last) begin
            state_d     = IDLE;
            row_valid_d = '0;
            row_idx_d   = '0;
            col_idx_d   = '0;
            done_d      = 1'b1;
          end else if (col_idx_q == LAST_COL) begin
            col_idx_d = '0;
            row_idx_d = row_idx_q + 1'b1;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_valid_q <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign outValid = (state_q == DRAIN);
  assign busy     = (state_q != IDLE);
  assign outData  = rd_row[col_idx_q*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  assign outRow   = row_idx_q;
  assign outCol   = col_idx_q;
  assign outLast  = outValid && at_last;
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_matrix_output_drain.sv
// Directed bench for matrix_output_drain: fill orders, backpressure, overrun,
// mid-drain reset and back-to-back matrices, checked against a local row model.
module tb_matrix_output_drain;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] outputData = '0;
  logic [2:0]   outputAddr = '0;
  logic         outputWrEn = 1'b0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [15:0]  outData;
  logic [2:0]   outRow;
  logic [2:0]   outCol;
  logic         outLast;
  logic         busy;
  logic         done;
  logic         overrun;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_mem [8][8];

  always #5 clk = ~clk;

  matrix_output_drain #(
    .BATCH_SIZE          (8),
    .LOG_BATCH_SIZE      (3),
    .OUTPUT_FEATURES     (8),
    .LOG_OUTPUT_FEATURES (3),
    .OUTPUT_WIDTH        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .outputData (outputData),
    .outputAddr (outputAddr),
    .outputWrEn (outputWrEn),
    .outValid   (outValid),
    .outReady   (outReady),
    .outData    (outData),
    .outRow     (outRow),
    .outCol     (outCol),
    .outLast    (outLast),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_row(input logic [15:0] base);
    logic [127:0] row;
    for (int c = 0; c < 8; c++) row[c*16 +: 16] = base + 16'(c);
    return row;
  endfunction

  function automatic logic [127:0] mk_const(input logic [15:0] v);
    logic [127:0] row;
    for (int c = 0; c < 8; c++) row[c*16 +: 16] = v;
    return row;
  endfunction

  task automatic write_row(input logic [2:0] addr, input logic [127:0] data);
    outputWrEn = 1'b1;
    outputAddr = addr;
    outputData = data;
    for (int c = 0; c < 8; c++) exp_mem[addr][c] = data[c*16 +: 16];
    tick();
    outputWrEn = 1'b0;
  endtask

  // Rows 0..7, element (r,c) = offset + 0x100*r + c; checks fill latency.
  task automatic fill_in_order(input logic [15:0] offset);
    for (int r = 0; r < 8; r++) begin
      write_row(3'(r), mk_row(offset + 16'(r * 256)));
      chk("fill_busy", 32'(busy), 32'd1);
      chk("fill_valid", 32'(outValid), (r == 7) ? 32'd1 : 32'd0);
    end
  endtask

  // Streams the whole matrix; mode 1 applies ready pattern 1,0,0,1.
  // Returns positioned in the done cycle.
  task automatic drain_check(input int mode, input int ovr_at);
    int r = 0;
    int c = 0;
    int n = 0;
    int cyc = 0;
    bit rdy;
    bit stalled = 1'b0;
    logic [15:0] hold_d;
    logic [2:0]  hold_r;
    logic [2:0]  hold_c;
    while (n < 64 && cyc < 400) begin
      chk("drain_valid", 32'(outValid), 32'd1);
      if (stalled) begin
        chk("stall_data", 32'(outData), 32'(hold_d));
        chk("stall_row", 32'(outRow), 32'(hold_r));
        chk("stall_col", 32'(outCol), 32'(hold_c));
      end
      chk("data", 32'(outData), 32'(exp_mem[r][c]));
      chk("row", 32'(outRow), 32'(r));
      chk("col", 32'(outCol), 32'(c));
      chk("last", 32'(outLast), (r == 7 && c == 7) ? 32'd1 : 32'd0);
      chk("done_low", 32'(done), 32'd0);
      chk("overrun", 32'(overrun), (ovr_at >= 0 && cyc > ovr_at) ? 32'd1 : 32'd0);
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      outReady = rdy;
      if (cyc == ovr_at) begin
        outputWrEn = 1'b1;
        outputAddr = 3'd2;
        outputData = mk_const(16'hFFFF);
      end
      hold_d = outData;
      hold_r = outRow;
      hold_c = outCol;
      tick();
      outputWrEn = 1'b0;
      if (rdy) begin
        n++;
        stalled = 1'b0;
        if (c == 7) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end else begin
        stalled = 1'b1;
      end
      cyc++;
    end
    outReady = 1'b0;
    chk("drain_count", 32'(n), 32'd64);
    chk("end_valid", 32'(outValid), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_last", 32'(outLast), 32'd0);
    rst = 1'b0;
    tick();

    // In-order fill, free-running consumer
    fill_in_order(16'h0000);
    chk("first_elem", 32'(outData), 32'h0000);
    drain_check(0, -1);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_valid", 32'(outValid), 32'd0);

    // Out-of-order fill with duplicate row 3
    write_row(3'd3, mk_row(16'h0300));
    write_row(3'd0, mk_row(16'h0000));
    write_row(3'd7, mk_row(16'h0700));
    write_row(3'd3, mk_const(16'hBEEF));
    write_row(3'd1, mk_row(16'h0100));
    write_row(3'd2, mk_row(16'h0200));
    write_row(3'd4, mk_row(16'h0400));
    write_row(3'd5, mk_row(16'h0500));
    chk("ooo_not_yet", 32'(outValid), 32'd0);
    chk("ooo_busy", 32'(busy), 32'd1);
    write_row(3'd6, mk_row(16'h0600));
    chk("ooo_valid", 32'(outValid), 32'd1);
    chk("ooo_row3", 32'(exp_mem[3][5]), 32'hBEEF);
    drain_check(0, -1);
    tick();

    // Backpressure
    fill_in_order(16'h2000);
    drain_check(1, -1);
    tick();
    chk("bp_done_once", 32'(done), 32'd0);

    // Overrun during drain
    fill_in_order(16'h4000);
    drain_check(0, 4);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    tick();
    chk("ovr_sticky_idle", 32'(overrun), 32'd1);

    // Reset after 10 transfers
    fill_in_order(16'h5000);
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("pre_rst_data", 32'(outData), 32'(exp_mem[i / 8][i % 8]));
      tick();
    end
    rst = 1'b1;
    outReady = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(outValid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    fill_in_order(16'h6000);
    chk("post_rst_row", 32'(outRow), 32'd0);
    chk("post_rst_col", 32'(outCol), 32'd0);
    drain_check(0, -1);
    tick();

    // Back-to-back: second fill begins in the done cycle
    fill_in_order(16'h7000);
    drain_check(0, -1);
    fill_in_order(16'h8000);
    drain_check(0, -1);
    tick();
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_output_drain.md
Name: matrix_output_drain

Overview:
Downstream consumer of the matrix multiply engine's write port (outputData / outputAddr / outputWrEn).
- Captures the BATCH_SIZE result rows, each OUTPUT_FEATURES elements wide, into an internal row buffer.
- Once all rows are present, serializes the matrix element-by-element over a valid/ready stream in row-major order.
- Lets a narrow consumer (DMA, AXI-Stream bridge) accept results at its own rate.

Parameters:
- BATCH_SIZE, 8, number of result rows (M)
- LOG_BATCH_SIZE, 3, row address width
- OUTPUT_FEATURES, 8, elements per row (O)
- LOG_OUTPUT_FEATURES, 3, column index width
- OUTPUT_WIDTH, 16, bits per element

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- outputData  in  OUTPUT_FEATURES*OUTPUT_WIDTH  result row from engine; element c at bits [c*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- outputAddr  in  LOG_BATCH_SIZE  row index of outputData
- outputWrEn  in  1  row write strobe
- outValid  out  1  stream data valid
- outReady  in  1  stream consumer ready
- outData  out  OUTPUT_WIDTH  current element
- outRow  out  LOG_BATCH_SIZE  row index of outData
- outCol  out  LOG_OUTPUT_FEATURES  column index of outData
- outLast  out  1  high with the final element (row BATCH_SIZE-1, col OUTPUT_FEATURES-1)
- busy  out  1  high in FILL or DRAIN
- done  out  1  one-cycle pulse after the last element is accepted
- overrun  out  1  sticky; a row write arrived during DRAIN

Behaviour:
- Reset: state=IDLE; rowValid bitmap=0; rowIdx=0; colIdx=0; outValid=0; outLast=0; busy=0; done=0; overrun=0. Buffer contents are not cleared and are don't-care.
- Reset mid-operation is allowed in any state and returns the block to the reset state at the next edge.
- States: IDLE, FILL, DRAIN.
- IDLE: on outputWrEn, write buffer[outputAddr]=outputData, set rowValid[outputAddr], go to FILL.
- FILL: on outputWrEn, write the row and set its bit.
  - A repeated address overwrites the row; the bitmap is unchanged.
  - Rows may arrive in any order, with any gaps between them.
  - When the write being performed makes rowValid all ones, go to DRAIN at that same edge.
  - If BATCH_SIZE==1, IDLE goes directly to DRAIN.
- Fill latency: outValid rises in the cycle after the edge that captured the last missing row.
- DRAIN:
  - outValid=1.
  - outData = buffer[rowIdx][colIdx*OUTPUT_WIDTH +: OUTPUT_WIDTH]; outRow=rowIdx; outCol=colIdx.
  - outLast = (rowIdx==BATCH_SIZE-1 && colIdx==OUTPUT_FEATURES-1).
- Handshake: a transfer occurs on an edge where outValid && outReady.
  - While outValid && !outReady, outData, outRow, outCol and outLast hold stable.
  - outValid never drops before a transfer.
- Index advance on transfer: colIdx increments; at OUTPUT_FEATURES-1 it wraps to 0 and rowIdx increments.
- Transfer with outLast:
  - Next cycle: outValid=0, done=1 for exactly one cycle.
  - rowValid, rowIdx and colIdx are cleared; state returns to IDLE.
  - Back-to-back operation: a new outputWrEn in the done cycle is captured normally in IDLE.
- outputWrEn during DRAIN: write is dropped, buffer unchanged, overrun=1 until rst.
- Elements pass through unmodified; no arithmetic, sign handling or saturation.
- busy = (state != IDLE).
- Throughput: one element per cycle with outReady held high. Drain takes BATCH_SIZE*OUTPUT_FEATURES cycles.

Decomposition:
- Shared package:
  - state enum {IDLE, FILL, DRAIN}
  - default parameter constants, shared with matrixMult and its testbench
  - element slice helper function
- One natural sub-module, matrix_row_buffer: BATCH_SIZE x (OUTPUT_FEATURES*OUTPUT_WIDTH) register array with one synchronous write port and one combinational read port.
- FSM, counters and handshake stay in the top module.

Test Plan:
- In-order fill, outReady=1: rows 0..7, element (r,c) = 16'h0100*r + c.
  - outValid rises 1 cycle after row 7 is written.
  - 64 consecutive transfers: first 16'h0000, last 16'h0707.
  - outLast only on (7,7); done pulses once.
- Out-of-order fill with duplicate: addresses 3,0,7,3,1,2,4,5,6; second write to row 3 = all 16'hBEEF.
  - DRAIN entered only after row 6; row 3 streams eight 16'hBEEF.
- Backpressure: outReady toggles 1,0,0,1 repeating.
  - Data and indices stay stable across stalled cycles; no element lost or duplicated; 64 transfers total.
- Overrun: write row 2 = 16'hFFFF-filled at the 5th DRAIN cycle.
  - overrun=1 and stays 1; streamed row 2 keeps its original values.
- Reset mid-DRAIN: assert rst after 10 transfers.
  - Next cycle: outValid=0, busy=0, done=0, overrun=0.
  - A fresh 8-row fill then streams from (0,0).
- Back-to-back matrices: second fill starts in the done cycle; both matrices stream correctly; done pulses twice.
